sensor_power_sequencer: RTL and testbench
=========================================

Name: sensor_power_sequencer

Overview:
- Downstream consumer of the board-level `hw_reset`.
- Once `hw_reset` releases, brings the camera sensor out of power-down and out of reset, then launches its register configuration and waits for it to finish.
- Holds the video/path-finding pipeline in reset until the sensor is configured.
- Retries failed bring-ups a bounded number of times, then raises a sticky fault.

Parameters:
- W, 16: width of the shared delay/timeout counter; every delay parameter must fit in W bits.
- PWR_DLY, 27000: cycles of power-up settle after `cam_pwdn` deasserts (1 ms at 27 MHz). Also the power-cycle hold time on retry. Must be ≥1.
- SETTLE_DLY, 2700: cycles after `cam_rst_n` releases before configuration starts. Must be ≥1.
- CFG_TIMEOUT, 65535: maximum cycles to wait for `cfg_done`/`cfg_err`. Must be ≥1.
- MAX_RETRY, 3: number of re-attempts after the first failure before fault. Range 0..3.

Ports:
- clk  in  1  system clock (27 MHz)
- hw_reset  in  1  synchronous, active-high reset
- cfg_done  in  1  configurator success pulse/level
- cfg_err  in  1  configurator failure pulse/level
- rearm  in  1  request to restart the sequence from power-down
- cam_pwdn  out  1  sensor power-down, active-high
- cam_rst_n  out  1  sensor reset, active-low
- cfg_start  out  1  one-cycle configuration start strobe
- pipe_reset  out  1  pipeline reset, active-high
- seq_ready  out  1  sensor configured, pipeline running
- seq_fault  out  1  sticky failure flag
- retry_cnt  out  2  number of retries consumed

Behaviour:
- Reset is synchronous; `hw_reset` is sampled only on the `clk` rising edge.
- While `hw_reset` = 1:
  - state = S_IDLE.
  - Outputs: `cam_pwdn`=1, `cam_rst_n`=0, `cfg_start`=0, `pipe_reset`=1, `seq_ready`=0, `seq_fault`=0, `retry_cnt`=0, counter=0.
- All outputs are registered and change on the same edge as the state transition that selects them.
- Delay semantics: each timed state lasts exactly its parameter value in cycles, counted from the entry edge.
- States and transitions:
  - S_IDLE: on the first edge with `hw_reset`=0, go to S_PWRUP.
  - S_PWRUP: `cam_pwdn`=0, `cam_rst_n`=0. After PWR_DLY cycles, go to S_RSTREL.
  - S_RSTREL: `cam_pwdn`=0, `cam_rst_n`=1. After SETTLE_DLY cycles, go to S_CFG.
  - S_CFG: `cfg_start`=1 only in the first cycle of the state. `cfg_done`/`cfg_err` are sampled in cycles 1..CFG_TIMEOUT, with the strobe cycle counted as cycle 1.
    - `cfg_err`=1 → failure.
    - Otherwise `cfg_done`=1 → S_RUN.
    - Neither by cycle CFG_TIMEOUT → failure (timeout).
  - Failure handling:
    - If `retry_cnt` < MAX_RETRY: increment `retry_cnt`, go to S_RETRY.
    - Otherwise go to S_FAULT; `retry_cnt` keeps its value.
  - S_RETRY: `cam_pwdn`=1, `cam_rst_n`=0, `pipe_reset`=1. After PWR_DLY cycles, go to S_PWRUP.
  - S_RUN: `pipe_reset`=0, `seq_ready`=1, camera outputs as in S_RSTREL.
    - `rearm`=1 → clear `retry_cnt`, go to S_RETRY; `pipe_reset`=1 and `seq_ready`=0 on that edge.
  - S_FAULT: `seq_fault`=1, `cam_pwdn`=1, `cam_rst_n`=0, `pipe_reset`=1.
    - `rearm`=1 → clear `seq_fault` and `retry_cnt`, go to S_RETRY.
- `pipe_reset`=1 in every state except S_RUN; `seq_ready` = (state == S_RUN).
- Boundary conditions:
  - `cfg_done` and `cfg_err` in the same cycle: error wins.
  - `cfg_done` in the last allowed cycle (CFG_TIMEOUT): accepted, no timeout.
  - `cfg_done`/`cfg_err` outside S_CFG: ignored.
  - `rearm` outside S_RUN/S_FAULT: ignored.
  - `rearm` in the same cycle as `hw_reset`: reset wins.
  - `hw_reset` asserted in any state: next edge returns to S_IDLE with all reset values. An in-flight configuration is abandoned with no `cfg_start` re-issue.
  - `retry_cnt` saturates at MAX_RETRY and never wraps.
  - MAX_RETRY=0: the first failure goes straight to S_FAULT.
- Counter: one W-bit down-counter, loaded on every state entry and decremented each cycle. Its terminal count determines the state exit.

Test Plan:
- Bench parameters: PWR_DLY=4, SETTLE_DLY=3, CFG_TIMEOUT=8, MAX_RETRY=2. Edge E0 is the first edge with `hw_reset`=0.
- Nominal bring-up:
  - `cam_pwdn` falls at E0; `cam_rst_n` rises at E0+4.
  - `cfg_start` is high for exactly the cycle following E0+7.
  - `cfg_done` in the 3rd S_CFG cycle → at E0+10, `pipe_reset`=0, `seq_ready`=1, `retry_cnt`=0.
- Timeout and retries:
  - No `cfg_done` ever → S_CFG exits after 8 cycles; `retry_cnt`=1; `cam_pwdn`=1 and `cam_rst_n`=0 held for 4 cycles; sequence replays.
  - Third consecutive timeout → `seq_fault`=1 (sticky), `retry_cnt`=2, `pipe_reset`=1.
- `cfg_done`=`cfg_err`=1 in the same cycle → treated as failure; `retry_cnt` 0→1; `seq_ready` stays 0.
- Timeout boundary:
  - `cfg_done` in S_CFG cycle 8 → S_RUN reached.
  - Separate run with `cfg_done` first in cycle 9 → timeout already taken; the late pulse is ignored.
- `rearm` handling:
  - `rearm` pulse in S_RUN → next edge `pipe_reset`=1, `seq_ready`=0, `cam_pwdn`=1; full sequence replays.
  - `rearm` in S_PWRUP → no effect on timing.
  - `rearm` in S_FAULT → `seq_fault` clears and `retry_cnt`=0.
- `hw_reset` for 1 cycle mid-S_CFG → next edge all outputs at reset values; the sequence restarts from E0 timing after release.

Source files
------------

// File: rtl/sensor_power_sequencer.sv
// Camera sensor power/reset sequencer: power-up settle, reset release,
// configuration launch with timeout, bounded retries and a sticky fault.
// Holds the downstream pipeline in reset until the sensor is configured.
module sensor_power_sequencer #(
  parameter int W           = 16,
  parameter int PWR_DLY     = 27000,
  parameter int SETTLE_DLY  = 2700,
  parameter int CFG_TIMEOUT = 65535,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       hw_reset,
  input  logic       cfg_done,
  input  logic       cfg_err,
  input  logic       rearm,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       pipe_reset,
  output logic       seq_ready,
  output logic       seq_fault,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_RSTREL, S_CFG, S_RETRY, S_RUN, S_FAULT
  } state_t;

  // Counter reload values: a state lasting N cycles counts N-1 down to 0.
  localparam logic [W-1:0] PWR_LD    = W'(PWR_DLY - 1);
  localparam logic [W-1:0] SETTLE_LD = W'(SETTLE_DLY - 1);
  localparam logic [W-1:0] CFG_LD    = W'(CFG_TIMEOUT - 1);
  localparam logic [1:0]   RETRY_MAX = 2'(MAX_RETRY);

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [1:0]     retry_q, retry_d;
  logic           cam_pwdn_q, cam_pwdn_d;
  logic           cam_rst_n_q, cam_rst_n_d;
  logic           cfg_start_q, cfg_start_d;
  logic           pipe_reset_q, pipe_reset_d;
  logic           seq_ready_q, seq_ready_d;
  logic           seq_fault_q, seq_fault_d;
  logic           fail;
  logic           cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter and retry bookkeeping; outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_PWRUP;
      S_PWRUP: begin
        if (cnt_zero) state_d = S_RSTREL;
        else          cnt_d   = cnt_q - 1'b1;
      end
      S_RSTREL: begin
        if (cnt_zero) state_d = S_CFG;
        else          cnt_d   = cnt_q - 1'b1;
      end
      S_CFG: begin
        // Error wins over a simultaneous done; done in the final cycle is accepted.
        if (cfg_err || (!cfg_done && cnt_zero)) fail    = 1'b1;
        else if (cfg_done)                      state_d = S_RUN;
        else                                    cnt_d   = cnt_q - 1'b1;
      end
      S_RETRY: begin
        if (cnt_zero) state_d = S_PWRUP;
        else          cnt_d   = cnt_q - 1'b1;
      end
      S_RUN: begin
        if (rearm) begin
          retry_d = '0;
          state_d = S_RETRY;
        end
      end
      S_FAULT: begin
        if (rearm) begin
          retry_d = '0;
          state_d = S_RETRY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = S_RETRY;
      end else begin
        state_d = S_FAULT;
      end
    end

    // Reload the shared counter on every state entry.
    if (state_d != state_q) begin
      unique case (state_d)
        S_PWRUP, S_RETRY: cnt_d = PWR_LD;
        S_RSTREL:         cnt_d = SETTLE_LD;
        S_CFG:            cnt_d = CFG_LD;
        default:          cnt_d = '0;
      endcase
    end

    cam_pwdn_d   = (state_d inside {S_IDLE, S_RETRY, S_FAULT});
    cam_rst_n_d  = (state_d inside {S_RSTREL, S_CFG, S_RUN});
    cfg_start_d  = (state_d == S_CFG) && (state_q != S_CFG);
    pipe_reset_d = (state_d != S_RUN);
    seq_ready_d  = (state_d == S_RUN);
    seq_fault_d  = (state_d == S_FAULT);
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (hw_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      cam_pwdn_q   <= 1'b1;
      cam_rst_n_q  <= 1'b0;
      cfg_start_q  <= 1'b0;
      pipe_reset_q <= 1'b1;
      seq_ready_q  <= 1'b0;
      seq_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      cam_pwdn_q   <= cam_pwdn_d;
      cam_rst_n_q  <= cam_rst_n_d;
      cfg_start_q  <= cfg_start_d;
      pipe_reset_q <= pipe_reset_d;
      seq_ready_q  <= seq_ready_d;
      seq_fault_q  <= seq_fault_d;
    end
  end

  assign cam_pwdn   = cam_pwdn_q;
  assign cam_rst_n  = cam_rst_n_q;
  assign cfg_start  = cfg_start_q;
  assign pipe_reset = pipe_reset_q;
  assign seq_ready  = seq_ready_q;
  assign seq_fault  = seq_fault_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_sensor_power_sequencer.sv
// Directed bench for sensor_power_sequencer with short delays.
// Outputs are packed {cam_pwdn, cam_rst_n, cfg_start, pipe_reset,
// seq_ready, seq_fault, retry_cnt[1:0]} and compared to hand-derived codes.
module tb_sensor_power_sequencer;

  logic       clk = 1'b0;
  logic       hw_reset, cfg_done, cfg_err, rearm;
  logic       cam_pwdn, cam_rst_n, cfg_start, pipe_reset, seq_ready, seq_fault;
  logic [1:0] retry_cnt;
  logic [7:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  // Output codes with retry_cnt = 0; OR in the retry count where needed.
  localparam logic [7:0] C_IDLE  = 8'h90;
  localparam logic [7:0] C_PWRUP = 8'h10;
  localparam logic [7:0] C_RSTRL = 8'h50;
  localparam logic [7:0] C_CFG1  = 8'h70;
  localparam logic [7:0] C_CFGN  = 8'h50;
  localparam logic [7:0] C_RETRY = 8'h90;
  localparam logic [7:0] C_RUN   = 8'h48;
  localparam logic [7:0] C_FAULT = 8'h94;

  sensor_power_sequencer #(
    .W(16), .PWR_DLY(4), .SETTLE_DLY(3), .CFG_TIMEOUT(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .hw_reset(hw_reset), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .rearm(rearm), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .cfg_start(cfg_start), .pipe_reset(pipe_reset), .seq_ready(seq_ready),
    .seq_fault(seq_fault), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {cam_pwdn, cam_rst_n, cfg_start, pipe_reset, seq_ready, seq_fault, retry_cnt};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From just before the entry edge of S_PWRUP through the cfg_start cycle.
  // poke drives rearm/cfg_done/cfg_err in S_PWRUP and S_RSTREL; all must be ignored.
  task automatic bringup(input logic [1:0] rc, input bit poke);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pwrup", obs, C_PWRUP | {6'd0, rc});
      if (poke && i == 1) begin rearm = 1'b1; cfg_done = 1'b1; cfg_err = 1'b1; end
      else begin rearm = 1'b0; cfg_done = 1'b0; cfg_err = 1'b0; end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstrel", obs, C_RSTRL | {6'd0, rc});
      if (poke && i == 0) cfg_done = 1'b1;
      else                cfg_done = 1'b0;
    end
    step();
    chk("cfg_start", obs, C_CFG1 | {6'd0, rc});
  endtask

  // n_idle quiet configuration cycles, then one cycle with done/err driven.
  task automatic cfg_phase(input logic [1:0] rc, input int n_idle, input logic done,
                           input logic err, input logic [7:0] exp, input string tag);
    for (int i = 0; i < n_idle; i++) begin
      step();
      chk("cfg_wait", obs, C_CFGN | {6'd0, rc});
    end
    cfg_done = done;
    cfg_err  = err;
    step();
    chk(tag, obs, exp);
    cfg_done = 1'b0;
    cfg_err  = 1'b0;
  endtask

  // Remaining three cycles of the power-cycle hold after the entry edge.
  task automatic retry_hold(input logic [1:0] rc, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("retry_hold", obs, C_RETRY | {6'd0, rc});
    end
  endtask

  initial begin
    hw_reset = 1'b1; cfg_done = 1'b0; cfg_err = 1'b0; rearm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_state", obs, C_IDLE);
    end
    rearm    = 1'b0;
    hw_reset = 1'b0;

    // Nominal bring-up, done in the third configuration cycle.
    bringup(2'd0, 1'b0);
    cfg_phase(2'd0, 2, 1'b1, 1'b0, C_RUN, "nominal_run");
    step(); chk("run_hold", obs, C_RUN);

    // Rearm from S_RUN, replay with ignored pokes, then three timeouts to fault.
    rearm = 1'b1;
    step(); chk("rearm_run", obs, C_RETRY);
    rearm = 1'b0;
    retry_hold(2'd0, 3);
    bringup(2'd0, 1'b1);
    cfg_phase(2'd0, 7, 1'b0, 1'b0, C_RETRY | 8'd1, "timeout1");
    retry_hold(2'd1, 3);
    bringup(2'd1, 1'b0);
    cfg_phase(2'd1, 7, 1'b0, 1'b0, C_RETRY | 8'd2, "timeout2");
    retry_hold(2'd2, 3);
    bringup(2'd2, 1'b0);
    cfg_phase(2'd2, 7, 1'b0, 1'b0, C_FAULT | 8'd2, "timeout3_fault");
    step(); chk("fault_sticky", obs, C_FAULT | 8'd2);
    step(); chk("fault_sticky2", obs, C_FAULT | 8'd2);

    // Rearm from fault clears fault and retry count.
    rearm = 1'b1;
    step(); chk("rearm_fault", obs, C_RETRY);
    rearm = 1'b0;
    retry_hold(2'd0, 3);

    // Done and err together in the first configuration cycle: failure.
    bringup(2'd0, 1'b0);
    cfg_phase(2'd0, 0, 1'b1, 1'b1, C_RETRY | 8'd1, "done_err_same");
    retry_hold(2'd1, 3);

    // Done in the last allowed cycle is accepted.
    bringup(2'd1, 1'b0);
    cfg_phase(2'd1, 7, 1'b1, 1'b0, C_RUN | 8'd1, "done_last_cycle");
    rearm = 1'b1;
    step(); chk("rearm_clear_cnt", obs, C_RETRY);
    rearm = 1'b0;
    retry_hold(2'd0, 3);

    // Done one cycle too late: timeout already taken, pulse ignored.
    bringup(2'd0, 1'b0);
    cfg_phase(2'd0, 7, 1'b0, 1'b0, C_RETRY | 8'd1, "late_timeout");
    cfg_done = 1'b1;
    step(); chk("late_done_ignored", obs, C_RETRY | 8'd1);
    cfg_done = 1'b0;
    retry_hold(2'd1, 2);

    // One-cycle hw_reset in the middle of configuration.
    bringup(2'd1, 1'b0);
    step(); chk("cfg_mid", obs, C_CFGN | 8'd1);
    hw_reset = 1'b1;
    step(); chk("mid_cfg_reset", obs, C_IDLE);
    hw_reset = 1'b0;
    bringup(2'd0, 1'b0);
    cfg_phase(2'd0, 2, 1'b1, 1'b0, C_RUN, "restart_run");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
